// File: rtl/led_rgb_pkg.sv
// +---------------------------------------------------------------------------+
// | led_rgb_pkg : shared types, colour constants and colour lookup for the    |
// |               calculator RGB LED sequencer.  Revision 1.0                 |
// +---------------------------------------------------------------------------+
`default_nettype none

package led_rgb_pkg;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_FLASH     = 3'd1,
    S_OK        = 3'd2,
    S_ERR_BLINK = 3'd3,
    S_ERR_HOLD  = 3'd4
  } led_state_t;

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } blink_phase_t;

  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;

  localparam logic [1:0] ESTADO_RESULT = 2'd3;

  function automatic logic [2:0] state_colour(input led_state_t state,
                                              input blink_phase_t phase);
    logic [2:0] colour;
    colour = RGB_OFF;
    case (state)
      S_FLASH:     colour = RGB_BLUE;
      S_OK:        colour = RGB_GREEN;
      S_ERR_BLINK: colour = (phase == PH_ON) ? RGB_RED : RGB_OFF;
      S_ERR_HOLD:  colour = RGB_RED;
      default:     colour = RGB_OFF;
    endcase
    return colour;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_gen.sv
// +---------------------------------------------------------------------------+
// | led_pwm_gen : free-running PWM counter with brightness compare.           |
// |               Revision 1.0                                                |
// +---------------------------------------------------------------------------+
`default_nettype none

module led_pwm_gen #(
  parameter int PWM_BITS = 8,
  parameter int BRIGHT   = 64
) (
  input  logic clk,
  input  logic rst_n,
  output logic pwm_on
);

  // One extra bit so BRIGHT == 2**PWM_BITS still compares correctly.
  localparam logic [PWM_BITS:0] c_bright = (PWM_BITS + 1)'(BRIGHT);
  localparam logic              c_full   = (BRIGHT >= ((2 ** PWM_BITS) - 1));

  logic [PWM_BITS-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign pwm_on = ({1'b0, r_cnt} < c_bright) | c_full;

endmodule

`default_nettype wire

// File: rtl/led_rgb_sequencer.sv
// +---------------------------------------------------------------------------+
// | led_rgb_sequencer : result/error/key-press driven RGB LED sequencer with  |
// |                     PWM dimming.  Revision 1.0                            |
// +---------------------------------------------------------------------------+
`default_nettype none

module led_rgb_sequencer
  import led_rgb_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int BRIGHT       = 64,
  parameter int BLINK_HALF   = 25_000_000,
  parameter int BLINK_COUNT  = 3,
  parameter int FLASH_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] estado,
  input  logic       error,
  input  logic       key_press,
  output logic [2:0] rgb,
  output logic       active
);

  localparam int c_timer_max = (BLINK_HALF > FLASH_CYCLES) ? BLINK_HALF : FLASH_CYCLES;
  localparam int c_timer_w   = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;
  localparam int c_blink_w   = (BLINK_COUNT > 0) ? $clog2(BLINK_COUNT + 1) : 1;

  localparam logic [c_timer_w-1:0] c_blink_reload = c_timer_w'(BLINK_HALF - 1);
  localparam logic [c_timer_w-1:0] c_flash_reload = c_timer_w'(FLASH_CYCLES - 1);
  localparam logic [c_blink_w-1:0] c_blink_last   = c_blink_w'(BLINK_COUNT);

  led_state_t          r_state,     w_state_nxt;
  blink_phase_t        r_phase,     w_phase_nxt;
  logic [c_timer_w-1:0] r_timer,    w_timer_nxt;
  logic [c_blink_w-1:0] r_blink_cnt, w_blink_nxt;
  logic                r_res_prev;
  logic [2:0]          r_rgb;

  logic                w_res;
  logic                w_res_rise;
  logic                w_in_result;
  logic                w_pwm_on;
  logic [c_blink_w-1:0] w_blink_inc;

  assign w_res       = (estado == ESTADO_RESULT);
  assign w_res_rise  = w_res & ~r_res_prev;
  assign w_in_result = (r_state == S_OK) || (r_state == S_ERR_BLINK) || (r_state == S_ERR_HOLD);
  assign w_blink_inc = r_blink_cnt + 1'b1;

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS),
    .BRIGHT   (BRIGHT)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_on (w_pwm_on)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_OFF;
      r_phase     <= PH_OFF;
      r_timer     <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_timer     <= w_timer_nxt;
      r_blink_cnt <= w_blink_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_timer_nxt = r_timer;
    w_blink_nxt = r_blink_cnt;

    if (!w_res && w_in_result) begin
      w_state_nxt = S_OFF;
    end else if (w_res_rise && error) begin
      w_state_nxt = S_ERR_BLINK;
      w_phase_nxt = PH_ON;
      w_timer_nxt = c_blink_reload;
      w_blink_nxt = '0;
    end else if (w_res_rise) begin
      w_state_nxt = S_OK;
    end else if (key_press && !w_res && ((r_state == S_OFF) || (r_state == S_FLASH))) begin
      // A retrigger restarts the full flash duration.
      w_state_nxt = S_FLASH;
      w_timer_nxt = c_flash_reload;
    end else begin
      case (r_state)
        S_FLASH: begin
          if (r_timer == '0) begin
            w_state_nxt = S_OFF;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        S_ERR_BLINK: begin
          if (r_timer != '0) begin
            w_timer_nxt = r_timer - 1'b1;
          end else if (r_phase == PH_ON) begin
            w_phase_nxt = PH_OFF;
            w_timer_nxt = c_blink_reload;
          end else if (w_blink_inc >= c_blink_last) begin
            // Last OFF half-period done: settle on steady red.
            w_state_nxt = S_ERR_HOLD;
            w_blink_nxt = w_blink_inc;
          end else begin
            w_phase_nxt = PH_ON;
            w_timer_nxt = c_blink_reload;
            w_blink_nxt = w_blink_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_prev <= 1'b0;
      r_rgb      <= RGB_OFF;
    end else begin
      r_res_prev <= w_res;
      r_rgb      <= state_colour(r_state, r_phase) & {3{w_pwm_on}};
    end
  end

  assign rgb    = r_rgb;
  assign active = (r_state != S_OFF);

endmodule

`default_nettype wire

// File: tb/tb_led_rgb_sequencer.sv
// +---------------------------------------------------------------------------+
// | tb_led_rgb_sequencer : directed self-checking bench for the RGB LED       |
// |                        sequencer.  Revision 1.0                           |
// +---------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_led_rgb_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] estado = 2'd0;
  logic       error = 1'b0;
  logic       key_press = 1'b0;

  logic [2:0] rgb, rgb_dim, rgb_dark;
  logic       active, active_dim, active_dark;

  int checks = 0;
  int errors = 0;
  int dark_lit = 0;

  always #5 clk = ~clk;

  led_rgb_sequencer #(
    .PWM_BITS(4), .BRIGHT(15), .BLINK_HALF(10), .BLINK_COUNT(2), .FLASH_CYCLES(6)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .estado(estado), .error(error),
    .key_press(key_press), .rgb(rgb), .active(active)
  );

  led_rgb_sequencer #(
    .PWM_BITS(4), .BRIGHT(4), .BLINK_HALF(10), .BLINK_COUNT(2), .FLASH_CYCLES(6)
  ) u_dim (
    .clk(clk), .rst_n(rst_n), .estado(estado), .error(error),
    .key_press(key_press), .rgb(rgb_dim), .active(active_dim)
  );

  led_rgb_sequencer #(
    .PWM_BITS(4), .BRIGHT(0), .BLINK_HALF(10), .BLINK_COUNT(2), .FLASH_CYCLES(6)
  ) u_dark (
    .clk(clk), .rst_n(rst_n), .estado(estado), .error(error),
    .key_press(key_press), .rgb(rgb_dark), .active(active_dark)
  );

  always @(negedge clk) begin
    if (rgb_dark !== 3'b000) dark_lit++;
  end

  typedef struct {
    logic [1:0] estado;
    logic       error;
    logic       kp;
    logic [2:0] rgb;
    logic       act;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  // Inputs are applied just after an edge; outputs are read 1ns after the next one.
  task automatic step(input logic [1:0] e, input logic er, input logic kp);
    estado    = e;
    error     = er;
    key_press = kp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lit;
    int other;
    logic [2:0] exp_rgb;

    // Same-cycle key/result, ignored key and error while in result, flash abort.
    tbl[0]  = '{2'd3, 1'b0, 1'b1, 3'b000, 1'b1};
    tbl[1]  = '{2'd3, 1'b0, 1'b0, 3'b010, 1'b1};
    tbl[2]  = '{2'd3, 1'b0, 1'b0, 3'b010, 1'b1};
    tbl[3]  = '{2'd3, 1'b0, 1'b1, 3'b010, 1'b1};
    tbl[4]  = '{2'd3, 1'b0, 1'b0, 3'b010, 1'b1};
    tbl[5]  = '{2'd3, 1'b0, 1'b0, 3'b010, 1'b1};
    tbl[6]  = '{2'd3, 1'b1, 1'b0, 3'b010, 1'b1};
    tbl[7]  = '{2'd3, 1'b1, 1'b0, 3'b010, 1'b1};
    tbl[8]  = '{2'd3, 1'b1, 1'b1, 3'b010, 1'b1};
    tbl[9]  = '{2'd0, 1'b1, 1'b0, 3'b010, 1'b0};
    tbl[10] = '{2'd0, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[11] = '{2'd0, 1'b0, 1'b1, 3'b000, 1'b1};
    tbl[12] = '{2'd0, 1'b0, 1'b0, 3'b001, 1'b1};
    tbl[13] = '{2'd3, 1'b0, 1'b0, 3'b001, 1'b1};
    tbl[14] = '{2'd3, 1'b0, 1'b0, 3'b010, 1'b1};
    tbl[15] = '{2'd0, 1'b0, 1'b0, 3'b010, 1'b0};
    tbl[16] = '{2'd0, 1'b0, 1'b0, 3'b000, 1'b0};

    // Reset held with a result already pending.
    rst_n = 1'b0; estado = 2'd3; error = 1'b0; key_press = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 8'(rgb), 8'b000);
    check("reset_active", 8'(active), 8'b0);
    rst_n = 1'b1;

    step(2'd3, 1'b0, 1'b0);
    check("ok_edge1_active", 8'(active), 8'b1);
    check("ok_edge1_rgb", 8'(rgb), 8'b000);
    step(2'd3, 1'b0, 1'b0);
    check("ok_edge2_rgb", 8'(rgb), 8'b010);

    lit = 0;
    other = 0;
    for (int i = 0; i < 16; i++) begin
      step(2'd3, 1'b0, 1'b0);
      check($sformatf("ok_hold[%0d]", i), 8'(rgb), 8'b010);
      if (rgb_dim[1]) lit++;
      if (rgb_dim[2] | rgb_dim[0]) other++;
    end
    check("dim_green_duty", 8'(lit), 8'd4);
    check("dim_other_bits", 8'(other), 8'd0);

    // Error result: two blinks then steady red.
    step(2'd0, 1'b0, 1'b0);
    step(2'd0, 1'b0, 1'b0);
    check("idle_rgb", 8'(rgb), 8'b000);
    check("idle_active", 8'(active), 8'b0);
    step(2'd3, 1'b1, 1'b0);
    check("err_active", 8'(active), 8'b1);
    for (int i = 1; i <= 45; i++) begin
      step(2'd3, 1'b1, 1'b0);
      exp_rgb = ((i <= 10) || ((i >= 21) && (i <= 30)) || (i >= 41)) ? 3'b100 : 3'b000;
      check($sformatf("blink[%0d]", i), 8'(rgb), 8'(exp_rgb));
    end
    step(2'd0, 1'b1, 1'b0);
    check("drop_lag_rgb", 8'(rgb), 8'b100);
    check("drop_active", 8'(active), 8'b0);
    step(2'd0, 1'b0, 1'b0);
    check("drop_rgb", 8'(rgb), 8'b000);

    // Single blue flash.
    step(2'd0, 1'b0, 1'b1);
    check("flash_start_rgb", 8'(rgb), 8'b000);
    check("flash_start_active", 8'(active), 8'b1);
    for (int i = 1; i <= 8; i++) begin
      step(2'd0, 1'b0, 1'b0);
      check($sformatf("flash_rgb[%0d]", i), 8'(rgb), (i <= 6) ? 8'b001 : 8'b000);
      check($sformatf("flash_act[%0d]", i), 8'(active), (i <= 5) ? 8'b1 : 8'b0);
    end

    // Retrigger in the fourth flash cycle.
    step(2'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      step(2'd0, 1'b0, (i == 3));
      check($sformatf("retrig_rgb[%0d]", i), 8'(rgb), (i <= 9) ? 8'b001 : 8'b000);
    end

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].estado, tbl[i].error, tbl[i].kp);
      check($sformatf("tbl_rgb[%0d]", i), 8'(rgb), 8'(tbl[i].rgb));
      check($sformatf("tbl_act[%0d]", i), 8'(active), 8'(tbl[i].act));
    end

    // Asynchronous reset in the middle of a blink.
    step(2'd3, 1'b1, 1'b0);
    repeat (4) step(2'd3, 1'b1, 1'b0);
    check("preblink_rgb", 8'(rgb), 8'b100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rgb", 8'(rgb), 8'b000);
    check("async_active", 8'(active), 8'b0);
    estado = 2'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(2'd0, 1'b1, 1'b0);
    check("post_reset_rgb", 8'(rgb), 8'b000);
    check("post_reset_active", 8'(active), 8'b0);

    check("dark_never_lit", 8'(dark_lit), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
